// File: rtl/vga_pkg.sv
// vga_pkg: timing constants, palette values, 2-bit colour codes and the
// receiver FSM state type. Shared by vga_rx and vga_color_decode.
package vga_pkg;

  // 800x525 frame at 25 MHz
  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;
  localparam int H_ACT_START = 144;
  localparam int V_ACT_START = 35;
  localparam int H_ACT       = 640;
  localparam int V_ACT       = 480;

  // Palette colours as {b,g,r}
  localparam logic [11:0] COL_BLACK = 12'h000;
  localparam logic [11:0] COL_BLUE  = 12'hF00;
  localparam logic [11:0] COL_GREEN = 12'h0F0;
  localparam logic [11:0] COL_RED   = 12'h00F;

  localparam logic [1:0] CODE_BLACK = 2'b00;
  localparam logic [1:0] CODE_BLUE  = 2'b01;
  localparam logic [1:0] CODE_GREEN = 2'b10;
  localparam logic [1:0] CODE_RED   = 2'b11;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/vga_color_decode.sv
// vga_color_decode: combinational mapping of a 12-bit {b,g,r} colour back to
// its 2-bit palette code.
//   rgb  in  12  colour as {b,g,r}
//   code out 2   00 black, 01 blue, 10 green, 11 red
//   err  out 1   colour is not one of the four palette values (code is 00)
module vga_color_decode
  import vga_pkg::*;
(
  input  logic [11:0] rgb,
  output logic [1:0]  code,
  output logic        err
);

  always_comb begin
    code = CODE_BLACK;
    err  = 1'b0;
    case (rgb)
      COL_BLACK: code = CODE_BLACK;
      COL_BLUE:  code = CODE_BLUE;
      COL_GREEN: code = CODE_GREEN;
      COL_RED:   code = CODE_RED;
      default:   err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/vga_rx.sv
// vga_rx: VGA receiver. Locks to the hs/vs timing of the transmitter,
// rebuilds the pixel row/col and decodes each active pixel to its palette
// code, producing frame-buffer write strobes for loopback self-test.
//   vga_clk    in   pixel clock, rising edge
//   clrn       in   asynchronous active-low reset
//   hs, vs     in   active-low syncs
//   r, g, b    in   4-bit colour channels
//   pix_we     out  strobe: pix_row/pix_col/pix_data valid
//   pix_row    out  active row, pix_col out active column
//   pix_data   out  decoded 2-bit palette code
//   locked     out  receiver is in LOCKED
//   frame_done out  pulse at each vs fall while LOCKED
//   timing_err out  pulse on a line/frame length or counter mismatch
//   color_err  out  pulse with pix_we when the colour is not in the palette
//   err_cnt    out  saturating count of timing errors seen while LOCKED
module vga_rx #(
  parameter int H_TOTAL     = vga_pkg::H_TOTAL,
  parameter int V_TOTAL     = vga_pkg::V_TOTAL,
  parameter int H_ACT_START = vga_pkg::H_ACT_START,
  parameter int V_ACT_START = vga_pkg::V_ACT_START,
  parameter int H_ACT       = vga_pkg::H_ACT,
  parameter int V_ACT       = vga_pkg::V_ACT
) (
  input  logic       vga_clk,
  input  logic       clrn,
  input  logic       hs,
  input  logic       vs,
  input  logic [3:0] r,
  input  logic [3:0] g,
  input  logic [3:0] b,
  output logic       pix_we,
  output logic [8:0] pix_row,
  output logic [9:0] pix_col,
  output logic [1:0] pix_data,
  output logic       locked,
  output logic       frame_done,
  output logic       timing_err,
  output logic       color_err,
  output logic [7:0] err_cnt
);
  import vga_pkg::*;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_FIRST = 10'(H_ACT_START);
  localparam logic [9:0] H_END   = 10'(H_ACT_START + H_ACT);
  localparam logic [9:0] V_FIRST = 10'(V_ACT_START);
  localparam logic [9:0] V_END   = 10'(V_ACT_START + V_ACT);

  rx_state_t   state, state_next;
  logic        hs_q, vs_q, hs_qp, vs_qp;
  logic [11:0] rgb_q;
  logic [9:0]  hcnt, vcnt, hcnt_next, vcnt_next;
  logic        first, first_next, bad, bad_next, restart;
  logic        hs_fall, vs_fall, mismatch, exempt, err_now, in_win, rx_locked;
  logic [1:0]  code;
  logic        code_err;

  vga_color_decode u_decode (
    .rgb  (rgb_q),
    .code (code),
    .err  (code_err)
  );

  assign hs_fall   = hs_qp & ~hs_q;
  assign vs_fall   = vs_qp & ~vs_q;
  assign rx_locked = (state == LOCKED);
  assign locked    = rx_locked;

  assign mismatch = (hs_fall && (hcnt != H_LAST))
                 || (vs_fall && (vcnt != V_LAST))
                 || (!hs_fall && (hcnt == H_LAST))
                 || (hs_fall && !vs_fall && (vcnt == V_LAST))
                 || (vs_fall && !hs_fall);

  // The first sync event after (re)entering ACQUIRE may land at an arbitrary
  // counter phase, so it cannot be judged.
  assign exempt  = (state == ACQUIRE) && first && (hs_fall || vs_fall);
  assign err_now = mismatch && !exempt && (state != SEARCH);

  assign in_win = (hcnt >= H_FIRST) && (hcnt < H_END)
               && (vcnt >= V_FIRST) && (vcnt < V_END);

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      hs_qp <= 1'b1;
      vs_qp <= 1'b1;
      rgb_q <= '0;
    end else begin
      hs_q  <= hs;
      vs_q  <= vs;
      hs_qp <= hs_q;
      vs_qp <= vs_q;
      rgb_q <= {b, g, r};
    end
  end

  // Restarting acquisition zeroes the counters so the frame that follows is
  // measured from a known vs fall.
  always_comb begin
    hcnt_next  = (hs_fall || hcnt == H_LAST) ? 10'd0 : hcnt + 10'd1;
    vcnt_next  = vcnt;
    state_next = state;
    first_next = first;
    bad_next   = bad;
    restart    = 1'b0;
    if (hs_fall) begin
      if (vs_fall)
        vcnt_next = 10'd0;
      else if (vcnt != V_LAST)
        vcnt_next = vcnt + 10'd1;
    end
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_next = ACQUIRE;
          restart    = 1'b1;
        end
      end
      ACQUIRE: begin
        if (vs_fall) begin
          if (bad || err_now || first)
            restart = 1'b1;
          else
            state_next = LOCKED;
        end else begin
          if (hs_fall)
            first_next = 1'b0;
          if (err_now)
            bad_next = 1'b1;
        end
      end
      LOCKED: begin
        if (err_now)
          state_next = SEARCH;
      end
      default: state_next = SEARCH;
    endcase
    if (restart) begin
      hcnt_next  = 10'd0;
      vcnt_next  = 10'd0;
      first_next = 1'b1;
      bad_next   = 1'b0;
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state <= SEARCH;
      hcnt  <= '0;
      vcnt  <= '0;
      first <= 1'b0;
      bad   <= 1'b0;
    end else begin
      state <= state_next;
      hcnt  <= hcnt_next;
      vcnt  <= vcnt_next;
      first <= first_next;
      bad   <= bad_next;
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      pix_we     <= 1'b0;
      pix_row    <= '0;
      pix_col    <= '0;
      pix_data   <= '0;
      color_err  <= 1'b0;
      timing_err <= 1'b0;
      frame_done <= 1'b0;
      err_cnt    <= '0;
    end else begin
      pix_we     <= rx_locked && in_win;
      color_err  <= rx_locked && in_win && code_err;
      timing_err <= err_now;
      frame_done <= rx_locked && vs_fall;
      if (rx_locked && in_win) begin
        pix_col  <= hcnt - H_FIRST;
        pix_row  <= 9'(vcnt - V_FIRST);
        pix_data <= code;
      end
      if (rx_locked && err_now && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
